uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N/E/O framing with 1 or 2 stop bits, LSB first.
// One bit-timer reload per bit boundary; tx_out comes straight from a flop.
module uart_tx #(
    parameter int unsigned CLK_PER_BIT = 10,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // state | meaning
    // IDLE  | line high, waiting for tx_valid
    // START | start bit (low)
    // DATA  | eight data bits, LSB first
    // PAR   | parity bit (only when PARITY != 0)
    // STOP  | STOP_BITS stop bits (high); done pulses in the final cycle
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    localparam logic [15:0] RELOAD    = 16'(CLK_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic        ODD       = (PARITY == 2);

    state_t      state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        par_q;
    logic        tx_out_q;
    logic        done_q;
    logic        bit_end;

    assign bit_end = (timer_q == 16'd0);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            par_q     <= 1'b0;
            tx_out_q  <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                timer_q <= bit_end ? RELOAD : timer_q - 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_q   <= START;
                        shift_q   <= tx_data;
                        par_q     <= (^tx_data) ^ ODD;
                        tx_out_q  <= 1'b0;
                        timer_q   <= RELOAD;
                        bit_idx_q <= 3'd0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q  <= DATA;
                        tx_out_q <= shift_q[0];
                        shift_q  <= {1'b0, shift_q[7:1]};
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= 3'd0;
                            if (PARITY != 0) begin
                                state_q  <= PAR;
                                tx_out_q <= par_q;
                            end else begin
                                state_q  <= STOP;
                                tx_out_q <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_out_q  <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state_q   <= STOP;
                        tx_out_q  <= 1'b1;
                        bit_idx_q <= 3'd0;
                    end
                end
                STOP: begin
                    // Flag the final stop cycle one edge early so done stays registered.
                    if (timer_q == 16'd1 && bit_idx_q == LAST_STOP) begin
                        done_q <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_idx_q == LAST_STOP) begin
                            state_q   <= IDLE;
                            bit_idx_q <= 3'd0;
                            timer_q   <= 16'd0;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ready is gated by rst so it reads low during reset and high the cycle rst drops.
    assign tx_ready = (state_q == IDLE) && !rst;
    assign tx_busy  = !tx_ready;
    assign tx_out   = tx_out_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a negedge
// monitor captures the serial line and checks each frame when tx_done fires.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic [4:0] vld;
    logic [4:0] rdy_w, out_w, busy_w, done_w;
    int         total = 0;
    int         bad = 0;
    int         cur = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLK_PER_BIT(10), .PARITY(0), .STOP_BITS(1)) d0 (
        .clk_in(clk), .rst(rst), .tx_data(data), .tx_valid(vld[0]), .tx_ready(rdy_w[0]),
        .tx_out(out_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.CLK_PER_BIT(10), .PARITY(1), .STOP_BITS(1)) d1 (
        .clk_in(clk), .rst(rst), .tx_data(data), .tx_valid(vld[1]), .tx_ready(rdy_w[1]),
        .tx_out(out_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.CLK_PER_BIT(10), .PARITY(2), .STOP_BITS(1)) d2 (
        .clk_in(clk), .rst(rst), .tx_data(data), .tx_valid(vld[2]), .tx_ready(rdy_w[2]),
        .tx_out(out_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.CLK_PER_BIT(10), .PARITY(0), .STOP_BITS(2)) d3 (
        .clk_in(clk), .rst(rst), .tx_data(data), .tx_valid(vld[3]), .tx_ready(rdy_w[3]),
        .tx_out(out_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));
    uart_tx #(.CLK_PER_BIT(2), .PARITY(0), .STOP_BITS(1)) d4 (
        .clk_in(clk), .rst(rst), .tx_data(data), .tx_valid(vld[4]), .tx_ready(rdy_w[4]),
        .tx_out(out_w[4]), .tx_busy(busy_w[4]), .tx_done(done_w[4]));

    // len = cycles from accept edge to the tx_done cycle; len 0 means the frame must abort
    typedef struct {
        logic [7:0]  data;
        int          nslots;
        logic [11:0] pat;
        int          cpb;
        int          len;
    } frame_t;

    frame_t exp_q[$];

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // ---------------- monitor ----------------
    logic   line_v [0:511];
    int     cyc = 0;
    bit     active = 1'b0;
    bit     busy_ok = 1'b1;
    frame_t cur_f;

    task automatic finish_frame();
        check($sformatf("frame_len_d%02h", cur_f.data), cyc, cur_f.len);
        check($sformatf("busy_in_frame_d%02h", cur_f.data), int'(busy_ok), 1);
        for (int s = 0; s < cur_f.nslots; s++) begin
            int act_v;
            act_v = int'(cur_f.pat[s]);
            for (int c = s * cur_f.cpb + 1; c <= (s + 1) * cur_f.cpb; c++) begin
                if (c < 512 && line_v[c] !== cur_f.pat[s]) act_v = int'(!cur_f.pat[s]);
            end
            check($sformatf("slot%0d_d%02h", s, cur_f.data), act_v, int'(cur_f.pat[s]));
        end
    endtask

    always @(negedge clk) begin
        if (active && rst) begin
            check("abort_expected", (cur_f.len == 0) ? 1 : 0, 1);
            active = 1'b0;
        end else if (active) begin
            cyc++;
            if (cyc < 512) line_v[cyc] = out_w[cur];
            if (!busy_w[cur]) busy_ok = 1'b0;
            if (done_w[cur]) begin
                finish_frame();
                active = 1'b0;
            end else if (cyc > 400) begin
                check("frame_timeout", cyc, cur_f.len);
                active = 1'b0;
            end
        end else if (done_w[cur]) begin
            check("stray_done", 1, 0);
        end
        if (!rst && rdy_w[cur] && vld[cur]) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 1, 0);
            end else begin
                cur_f = exp_q.pop_front();
                check("idle_before_start", int'(out_w[cur]), 1);
                active  = 1'b1;
                cyc     = 0;
                busy_ok = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_exp(input logic [7:0] d, input bit pen, input bit pbit,
                            input int stops, input int cpb, input int len);
        frame_t f;
        f.data   = d;
        f.nslots = 1 + 8 + (pen ? 1 : 0) + stops;
        f.pat    = '1;
        f.pat[0] = 1'b0;
        f.pat[8:1] = d;
        if (pen) f.pat[9] = pbit;
        f.cpb    = cpb;
        f.len    = len;
        exp_q.push_back(f);
    endtask

    task automatic drive(input int inst, input logic [7:0] d);
        cur       = inst;
        data      = d;
        vld[inst] = 1'b1;
        @(posedge clk);
        #1;
        vld[inst] = 1'b0;
    endtask

    task automatic send(input int inst, input logic [7:0] d, input bit pen, input bit pbit,
                        input int stops, input int cpb, input int len);
        push_exp(d, pen, pbit, stops, cpb, len);
        drive(inst, d);
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (!active && exp_q.size() == 0 && rdy_w[cur]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        #1;
    endtask

    initial begin
        bit ok;
        rst  = 1'b1;
        vld  = 5'd0;
        data = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_out", int'(out_w), 5'h1f);
        check("rst_ready", int'(rdy_w), 0);
        check("rst_busy", int'(busy_w), 5'h1f);
        check("rst_done", int'(done_w), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", int'(rdy_w), 5'h1f);
        check("post_rst_busy", int'(busy_w), 0);
        @(posedge clk);
        #1;

        // default framing, two patterns
        send(0, 8'h55, 1'b0, 1'b0, 1, 10, 100);
        wait_idle(300);
        send(0, 8'hB4, 1'b0, 1'b0, 1, 10, 100);
        wait_idle(300);

        // even parity: 0x07 -> 1, 0x00 -> 0
        send(1, 8'h07, 1'b1, 1'b1, 1, 10, 110);
        wait_idle(300);
        send(1, 8'h00, 1'b1, 1'b0, 1, 10, 110);
        wait_idle(300);

        // odd parity: 0x07 -> 0, 0x03 -> 1
        send(2, 8'h07, 1'b1, 1'b0, 1, 10, 110);
        wait_idle(300);
        send(2, 8'h03, 1'b1, 1'b1, 1, 10, 110);
        wait_idle(300);

        // two stop bits, tx_valid held for two back-to-back bytes
        push_exp(8'hA3, 1'b0, 1'b0, 2, 10, 110);
        push_exp(8'h5C, 1'b0, 1'b0, 2, 10, 110);
        cur    = 3;
        data   = 8'hA3;
        vld[3] = 1'b1;
        @(posedge clk);
        #1 data = 8'h5C;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("second_accept_timeout", 0, 1);
        #1 vld[3] = 1'b0;
        wait_idle(300);

        // fastest bit rate; bit 7 occupies 0-based cycles 16-17
        send(4, 8'h80, 1'b0, 1'b0, 1, 2, 20);
        wait_idle(100);

        // valid with 0xFF at cycle 30 of a 0x00 frame must be ignored
        send(0, 8'h00, 1'b0, 1'b0, 1, 10, 100);
        repeat (29) @(posedge clk);
        #1;
        data   = 8'hFF;
        vld[0] = 1'b1;
        @(posedge clk);
        #1 vld[0] = 1'b0;
        wait_idle(300);
        repeat (30) @(posedge clk);
        #1;

        // reset at cycle 45 aborts the frame
        send(0, 8'h00, 1'b0, 1'b0, 1, 10, 0);
        repeat (44) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_tx_out", int'(out_w[0]), 1);
        check("abort_ready_in_rst", int'(rdy_w[0]), 0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", int'(rdy_w[0]), 1);
        check("abort_busy_after", int'(busy_w[0]), 0);
        check("abort_tx_out_after", int'(out_w[0]), 1);
        repeat (150) @(posedge clk);
        #1;

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
